// File: rtl/tk_sync_arbiter.sv
// Clocked N-way round-robin arbiter that shares one four-phase req/ack channel
// between N four-phase requesters; grant_id steers the downstream data mux.
module tk_sync_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] ack,
  output logic         out_r,
  input  logic         out_a,
  output logic [W-1:0] grant_id,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_RTZ} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   ptr_reg, ptr_next;
  logic [W-1:0]   grant_reg, grant_next;
  logic [N-1:0]   ack_reg, ack_next;
  logic           out_r_reg, out_r_next;
  logic           busy_reg, busy_next;

  logic [W:0]     cand_sum [N];
  logic [W-1:0]   cand_idx [N];
  logic [N-1:0]   cand_req;
  logic [N-1:0]   grant_onehot;
  logic [W-1:0]   winner;
  logic [W-1:0]   ptr_after;

  // Candidate at offset gi is (ptr + gi) mod N; offset 0 has highest priority.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr_reg} + (W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (W+1)'(N)) ?
                            W'(cand_sum[gi] - (W+1)'(N)) : cand_sum[gi][W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
      assign grant_onehot[gi] = (grant_reg == W'(gi));
    end
  endgenerate

  // Scan from lowest priority upward so the nearest set bit to ptr wins.
  always_comb begin
    winner = ptr_reg;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_req[i]) winner = cand_idx[i];
    end
  end

  assign ptr_after = (grant_reg == W'(N - 1)) ? '0 : grant_reg + W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      ack_reg   <= '0;
      out_r_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      out_r_reg <= out_r_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    ack_next   = ack_reg;
    out_r_next = out_r_reg;
    busy_next  = busy_reg;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          state_next = S_REQ;
          out_r_next = 1'b1;
          grant_next = winner;
          busy_next  = 1'b1;
        end
      end
      S_REQ: begin
        if (out_a) begin
          ack_next   = grant_onehot;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!req[grant_reg]) begin
          out_r_next = 1'b0;
          state_next = S_RTZ;
        end
      end
      S_RTZ: begin
        // Requester ack is held until the channel itself has returned to zero.
        if (!out_a) begin
          ack_next   = '0;
          busy_next  = 1'b0;
          ptr_next   = ptr_after;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ack      = ack_reg;
  assign out_r    = out_r_reg;
  assign grant_id = grant_reg;
  assign busy     = busy_reg;

`ifndef SYNTHESIS
  // Handshake protocol violations are flagged only; the FSM does not recover.
  always @(posedge clk) begin
    if (!reset) begin
      if (state_reg == S_REQ)
        assert (req[grant_reg]) else $error("winner dropped req before ack");
      if (state_reg == S_ACK)
        assert (out_a) else $error("channel dropped out_a while out_r high");
      assert ($onehot0(ack_reg)) else $error("more than one ack bit high");
    end
  end
`endif

endmodule

// File: tb/tb_tk_sync_arbiter.sv
// Directed bench for tk_sync_arbiter: stimulus pushes expected grant ids into a
// queue, a negedge monitor pops and compares them whenever out_r rises.
module tb_tk_sync_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic         out_r;
  logic         out_a = 1'b0;
  logic [W-1:0] grant_id;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int grant_count = 0;
  logic prev_out_r = 1'b0;

  always #5 clk = ~clk;

  tk_sync_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .out_r(out_r),
    .out_a(out_a), .grant_id(grant_id), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant order from the scoreboard, plus per-cycle ack invariants.
  always @(negedge clk) begin
    if (out_r && !prev_out_r) begin
      grant_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: grant_id=%0d, no grant expected", grant_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        check($sformatf("sb_grant%0d", grant_count), int'(grant_id), e);
        check($sformatf("sb_busy%0d", grant_count), int'(busy), 1);
        $display("grant %0d: grant_id=%0d expected=%0d", grant_count, grant_id, e);
      end
    end
    if (ack != '0) check("ack_onehot_winner", int'(ack), 1 << grant_id);
    if (out_r) check("out_r_implies_busy", int'(busy), 1);
    prev_out_r = out_r;
  end

  // One full handshake for requester id; req inputs are driven at negedges.
  task automatic do_grant(input int id, input int a_delay, input int rtz_delay,
                          input bit rereq, input logic [N-1:0] late_set,
                          input bit expect_now);
    int waited;
    exp_q.push_back(id);
    @(negedge clk);
    waited = 0;
    while (!out_r && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("out_r_rise_id%0d", id), int'(out_r), 1);
    if (expect_now) check($sformatf("grant_latency_id%0d", id), waited, 0);
    for (int i = 0; i < a_delay; i++) begin
      check("req_hold_out_r", int'(out_r), 1);
      check("req_hold_ack0", int'(ack), 0);
      @(negedge clk);
    end
    out_a = 1'b1;
    @(negedge clk);
    check($sformatf("ack_rise_id%0d", id), int'(ack), 1 << id);
    check("ack_out_r", int'(out_r), 1);
    req = req | late_set;
    req[id] = 1'b0;
    @(negedge clk);
    check("rtz_out_r0", int'(out_r), 0);
    check("rtz_ack_held", int'(ack), 1 << id);
    check("rtz_grant_stable", int'(grant_id), id);
    for (int i = 0; i < rtz_delay; i++) begin
      @(negedge clk);
      check("rtz_slow_ack_held", int'(ack), 1 << id);
      check("rtz_slow_busy", int'(busy), 1);
    end
    out_a = 1'b0;
    @(negedge clk);
    check("idle_ack0", int'(ack), 0);
    check("idle_busy0", int'(busy), 0);
    if (rereq) req[id] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Round robin from ptr=0 with every requester re-requesting, then drain.
    req = 4'b1111;
    do_grant(0, 0, 0, 1'b1, '0, 1'b1);
    do_grant(1, 0, 0, 1'b1, '0, 1'b1);
    do_grant(2, 0, 0, 1'b1, '0, 1'b1);
    do_grant(3, 0, 0, 1'b1, '0, 1'b1);
    do_grant(0, 0, 0, 1'b0, '0, 1'b1);
    do_grant(1, 0, 0, 1'b0, '0, 1'b1);
    do_grant(2, 0, 0, 1'b0, '0, 1'b1);
    do_grant(3, 0, 0, 1'b0, '0, 1'b1);

    // Single request from ptr=0; leaves ptr=3.
    req = 4'b0100;
    do_grant(2, 0, 0, 1'b0, '0, 1'b1);

    // Wrap-around: ptr=3 grants 3 then 0; then ptr=1 still grants 3 first.
    req = 4'b1001;
    do_grant(3, 0, 0, 1'b0, '0, 1'b1);
    do_grant(0, 0, 0, 1'b0, '0, 1'b1);
    req = 4'b1001;
    do_grant(3, 0, 0, 1'b0, '0, 1'b1);
    do_grant(0, 0, 0, 1'b0, '0, 1'b1);

    // Late arrival of req[1] while requester 0 is in ACK.
    req = 4'b0001;
    do_grant(0, 0, 0, 1'b0, 4'b0010, 1'b1);
    do_grant(1, 0, 0, 1'b0, '0, 1'b1);

    // Slow channel: ack delayed 5 cycles, return-to-zero delayed 3.
    req = 4'b0100;
    do_grant(2, 5, 3, 1'b0, '0, 1'b1);

    // Reset in ACK from ptr=3 with requester 1 holding its request.
    req = 4'b0010;
    exp_q.push_back(1);
    @(negedge clk);
    check("mid_out_r", int'(out_r), 1);
    out_a = 1'b1;
    @(negedge clk);
    check("mid_ack", int'(ack), 4'b0010);
    #2;
    reset = 1'b1;
    out_a = 1'b0;
    #1;
    check("async_rst_ack", int'(ack), 0);
    check("async_rst_out_r", int'(out_r), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_grant", int'(grant_id), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_grant(1, 0, 0, 1'b0, '0, 1'b1);

    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
